uart_tx_core: RTL and testbench

//   UART serializer. Takes a parallel word and transmits it on a single line as
//   a frame: start bit, data bits (LSB first), then stop time.
//   Bit timing comes from an external baud-rate generator that supplies
//   s_tick at 16x the baud rate. The block sits between the host/ALU interface
//   and the physical TX pin, and pulses tx_done_tick at the end of each frame.

---
 rtl/uart_tx_core_if.sv | 29 ++
 rtl/uart_tx_core.sv | 98 +++++++++
 tb/tb_uart_tx_core.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_core_if.sv
// Host-side bundle for the UART transmitter: bit-rate enable, word, request,
// and the serial line plus end-of-frame pulse.
interface uart_tx_core_if #(
  parameter int unsigned WIDTH_WORD_TX = 8
);
  logic                     s_tick;
  logic [WIDTH_WORD_TX-1:0] din;
  logic                     tx_start;
  logic                     tx;
  logic                     tx_done_tick;

  // Host / baud generator side drives the request and tick, sees the line.
  modport master (
    output s_tick,
    output din,
    output tx_start,
    input  tx,
    input  tx_done_tick
  );

  // Transmitter side.
  modport slave (
    input  s_tick,
    input  din,
    input  tx_start,
    output tx,
    output tx_done_tick
  );
endinterface

// File: rtl/uart_tx_core.sv
// UART serializer: start bit, WIDTH_WORD_TX data bits LSB first, then a stop
// period of CANT_BIT_STOP oversampling ticks. s_tick runs at 16x baud.
module uart_tx_core #(
  parameter int unsigned WIDTH_WORD_TX = 8,
  parameter int unsigned CANT_BIT_STOP = 16
) (
  input  logic           i_clk,
  input  logic           reset,
  uart_tx_core_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Tick counter must reach both 15 (one bit) and CANT_BIT_STOP-1 (stop time).
  localparam int unsigned SW = (CANT_BIT_STOP > 16) ? $clog2(CANT_BIT_STOP) : 4;
  localparam int unsigned NW = (WIDTH_WORD_TX > 1) ? $clog2(WIDTH_WORD_TX) : 1;

  localparam logic [SW-1:0] BitLast  = SW'(15);
  localparam logic [SW-1:0] StopLast = SW'(CANT_BIT_STOP - 1);
  localparam logic [NW-1:0] NLast    = NW'(WIDTH_WORD_TX - 1);

  state_e                   state_q;
  logic [SW-1:0]            s_q;
  logic [NW-1:0]            n_q;
  logic [WIDTH_WORD_TX-1:0] b_q;
  logic                     tx_q;

  logic bit_end;
  logic stop_end;

  // Last tick of a 16-tick bit cell, and of the stop period.
  assign bit_end  = bus.s_tick && (s_q == BitLast);
  assign stop_end = bus.s_tick && (s_q == StopLast);

  // Frame sequencer; the line level is registered from the current state so
  // it lags the state by one clock.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (bus.tx_start) begin
            b_q     <= bus.din;
            s_q     <= '0;
            state_q <= StStart;
          end
        end
        StStart: begin
          tx_q <= 1'b0;
          if (bit_end) begin
            s_q     <= '0;
            n_q     <= '0;
            state_q <= StData;
          end else if (bus.s_tick) begin
            s_q <= s_q + 1'b1;
          end
        end
        StData: begin
          tx_q <= b_q[0];
          if (bit_end) begin
            s_q <= '0;
            b_q <= b_q >> 1;
            if (n_q == NLast) begin
              state_q <= StStop;
            end else begin
              n_q <= n_q + 1'b1;
            end
          end else if (bus.s_tick) begin
            s_q <= s_q + 1'b1;
          end
        end
        StStop: begin
          tx_q <= 1'b1;
          if (stop_end) begin
            state_q <= StIdle;
          end else if (bus.s_tick) begin
            s_q <= s_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.tx           = tx_q;
  // Done fires on the final stop tick, in the same clock the FSM leaves StStop.
  assign bus.tx_done_tick = (state_q == StStop) && stop_end;

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: two instances (1 and 2 stop bits) share stimulus and
// are compared every cycle against a tick-count frame model.
module tb_uart_tx_core;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_tick = 1'b0;
  logic         tx_start = 1'b0;
  logic [W-1:0] din = '0;

  always #5 clk = ~clk;

  uart_tx_core_if #(.WIDTH_WORD_TX(W)) bus0 ();
  uart_tx_core_if #(.WIDTH_WORD_TX(W)) bus1 ();

  assign bus0.s_tick   = s_tick;
  assign bus0.din      = din;
  assign bus0.tx_start = tx_start;
  assign bus1.s_tick   = s_tick;
  assign bus1.din      = din;
  assign bus1.tx_start = tx_start;

  uart_tx_core #(.WIDTH_WORD_TX(W), .CANT_BIT_STOP(16)) dut0 (
    .i_clk (clk),
    .reset (rst),
    .bus   (bus0)
  );

  uart_tx_core #(.WIDTH_WORD_TX(W), .CANT_BIT_STOP(32)) dut1 (
    .i_clk (clk),
    .reset (rst),
    .bus   (bus1)
  );

  logic [1:0] tx_v;
  logic [1:0] done_v;
  assign tx_v   = {bus1.tx, bus0.tx};
  assign done_v = {bus1.tx_done_tick, bus0.tx_done_tick};

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int done_cnt[2];

  // Model state: is a frame in flight, how many ticks of it have elapsed, word.
  bit           m_busy[2];
  int           m_ticks[2];
  logic [W-1:0] m_word[2];
  logic         m_tx[2];

  function automatic int stop_len(int i);
    return (i == 0) ? 16 : 32;
  endfunction

  function automatic int frame_len(int i);
    return 16 + 16 * W + stop_len(i);
  endfunction

  // Line level implied by the frame position: start, data LSB first, stop.
  function automatic logic level(int i);
    int seg;
    if (!m_busy[i]) return 1'b1;
    seg = m_ticks[i] / 16;
    if (seg == 0) return 1'b0;
    if (seg <= W) return m_word[i][seg-1];
    return 1'b1;
  endfunction

  function automatic logic exp_done(int i);
    return m_busy[i] && s_tick && (m_ticks[i] == frame_len(i) - 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advance on each clock edge; the line after the edge shows the level
  // for the position held before it.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i]  = 1'b0;
        m_ticks[i] = 0;
        m_tx[i]    = 1'b1;
      end else begin
        m_tx[i] = level(i);
        if (!m_busy[i]) begin
          if (tx_start) begin
            m_busy[i]  = 1'b1;
            m_ticks[i] = 0;
            m_word[i]  = din;
          end
        end else if (s_tick) begin
          if (m_ticks[i] == frame_len(i) - 1) m_busy[i] = 1'b0;
          else m_ticks[i] = m_ticks[i] + 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("model_tx%0d", i), {31'b0, tx_v[i]}, {31'b0, m_tx[i]});
        check($sformatf("model_done%0d", i), {31'b0, done_v[i]}, {31'b0, exp_done(i)});
        if (done_v[i]) done_cnt[i]++;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One frame with s_tick every other clock; optional tx_start pulse mid-frame.
  task automatic send_frame(input logic [W-1:0] word, input bit pulse_mid);
    int           ticks;
    int           done_at[2];
    logic [W-1:0] cap[2];
    ticks       = 0;
    done_at[0]  = -1;
    done_at[1]  = -1;
    cap[0]      = '0;
    cap[1]      = '0;
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    din      = word;
    tx_start = 1'b1;
    s_tick   = 1'b0;
    cycle();
    tx_start = 1'b0;
    din      = ~word;
    for (int c = 1; c < 1000 && (done_at[0] < 0 || done_at[1] < 0); c++) begin
      s_tick = c[0];
      if (s_tick) ticks++;
      tx_start = pulse_mid && s_tick && (ticks == 50);
      @(negedge clk);
      if (s_tick) begin
        for (int i = 0; i < 2; i++) begin
          if (done_v[i] && done_at[i] < 0) done_at[i] = ticks;
          if (ticks == 8) check($sformatf("start_bit%0d", i), {31'b0, tx_v[i]}, 32'd0);
          for (int k = 0; k < W; k++)
            if (ticks == 16 * (k + 1) + 8) cap[i][k] = tx_v[i];
          if (ticks == 16 * (W + 1) + 8)
            check($sformatf("stop_bit%0d", i), {31'b0, tx_v[i]}, 32'd1);
        end
      end
      cycle();
    end
    s_tick   = 1'b0;
    tx_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("done_at_tick%0d", i), done_at[i], frame_len(i));
      check($sformatf("data_bits%0d", i), {24'b0, cap[i]}, {24'b0, word});
    end
    repeat (20) cycle();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("done_count%0d", i), done_cnt[i], 1);
      check($sformatf("idle_line%0d", i), {31'b0, tx_v[i]}, 32'd1);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) done_cnt[i] = 0;
    // Reset held for several cycles.
    rst = 1'b1;
    cycle();
    chk_en = 1'b1;
    repeat (3) cycle();
    check("reset_tx0", {31'b0, bus0.tx}, 32'd1);
    check("reset_tx1", {31'b0, bus1.tx}, 32'd1);
    check("reset_done0", {31'b0, bus0.tx_done_tick}, 32'd0);
    rst = 1'b0;
    repeat (10) cycle();
    check("idle_after_reset", {30'b0, tx_v}, 32'd3);

    // Literal pins on the model's frame lengths.
    check("frame_len_1stop", frame_len(0), 160);
    check("frame_len_2stop", frame_len(1), 176);

    send_frame(8'b1001_0110, 1'b0);
    send_frame(8'b1000_0110, 1'b0);
    send_frame(8'b0101_1100, 1'b1);

    // Reset during the data phase.
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    din      = 8'hA5;
    tx_start = 1'b1;
    cycle();
    tx_start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      s_tick = c[0];
      cycle();
    end
    s_tick = 1'b0;
    rst    = 1'b1;
    cycle();
    rst = 1'b0;
    check("reset_mid_tx", {30'b0, tx_v}, 32'd3);
    for (int c = 1; c <= 60; c++) begin
      s_tick = c[0];
      cycle();
    end
    s_tick = 1'b0;
    check("reset_mid_no_done0", done_cnt[0], 0);
    check("reset_mid_no_done1", done_cnt[1], 0);
    check("reset_mid_idle", {30'b0, tx_v}, 32'd3);

    send_frame(8'b1111_0001, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
